unstripe_sched: RTL and testbench

Two-lane scheduler and alignment controller for the byte-unstriping datapath, running in the `clk_2f` domain. Each stripe lane's bytes go into a per-lane FIFO. The block aligns the two lanes at the start of a burst, then pops them strictly in stripe order (lane 0, lane 1, lane 0, …) onto a single demux byte stream. It stalls without reordering when a lane runs dry, flags excessive lane skew and FIFO overflow, and holds in an error state until software clears it.

---
 rtl/unstripe_pkg.sv | 15 +
 rtl/lane_fifo.sv | 51 +++++
 rtl/unstripe_sched.sv | 174 +++++++++++++++++
 tb/tb_unstripe_sched.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/unstripe_pkg.sv
// Shared types and default sizing for the byte-unstriping scheduler.
package unstripe_pkg;

    localparam int unsigned DATA_W_DEF     = 8;
    localparam int unsigned FIFO_DEPTH_DEF = 4;
    localparam int unsigned MAX_SKEW_DEF   = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_RUN   = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

endpackage

// File: rtl/lane_fifo.sv
// Per-lane synchronous FIFO with wrap-bit pointers; a push while full without a pop is dropped.
module lane_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned LW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic [LW-1:0]     level,
    output logic              ovf
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [LW-1:0]     wptr;
    logic [LW-1:0]     rptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              do_push;
    logic              do_pop;

    assign level   = wptr - rptr;
    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_pop  = pop && !empty && !flush;
    // A pop frees the slot in the same cycle, so push+pop on a full FIFO is legal.
    assign do_push = push && !flush && (!full || do_pop);
    assign ovf     = push && full && !pop;
    assign dout    = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + LW'(1);
            if (do_pop)  rptr <= rptr + LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/unstripe_sched.sv
// Two-lane unstriping scheduler: aligns lane FIFOs at burst start, then pops them
// alternately (lane 0 first) onto one byte stream, trapping skew and overflow errors.
module unstripe_sched
    import unstripe_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned MAX_SKEW   = MAX_SKEW_DEF,
    localparam int unsigned LW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk_2f,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_stripe_0,
    input  logic              valid_stripe_0,
    input  logic [DATA_W-1:0] data_stripe_1,
    input  logic              valid_stripe_1,
    input  logic              clear_err,
    output logic [DATA_W-1:0] data_demux,
    output logic              valid_demux,
    output logic              lane_sel,
    output logic              aligned,
    output logic              skew_err,
    output logic              ovf_err,
    output logic [LW-1:0]     level_0,
    output logic [LW-1:0]     level_1
);

    localparam int unsigned SW = $clog2(MAX_SKEW + 1);

    state_t            state;
    state_t            state_n;
    logic              lane_sel_n;
    logic [SW-1:0]     skew_cnt;
    logic [SW-1:0]     skew_cnt_n;
    logic [DATA_W-1:0] data_n;
    logic              valid_n;
    logic              skew_err_n;
    logic              ovf_err_n;

    logic              push_0;
    logic              push_1;
    logic              pop;
    logic              flush;
    logic [DATA_W-1:0] dout_0;
    logic [DATA_W-1:0] dout_1;
    logic              empty_0;
    logic              empty_1;
    logic              full_0;
    logic              full_1;
    logic              ovf_0;
    logic              ovf_1;
    logic              unused_full;

    // ERR drops pushes and flushes both lanes every cycle.
    assign flush  = (state == ST_ERR);
    assign push_0 = valid_stripe_0 && !flush;
    assign push_1 = valid_stripe_1 && !flush;
    assign pop    = (state == ST_RUN) && !(lane_sel ? empty_1 : empty_0);
    assign unused_full = full_0 ^ full_1;

    lane_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo_0 (
        .clk   (clk_2f),
        .reset (reset),
        .push  (push_0),
        .pop   (pop && !lane_sel),
        .flush (flush),
        .din   (data_stripe_0),
        .dout  (dout_0),
        .empty (empty_0),
        .full  (full_0),
        .level (level_0),
        .ovf   (ovf_0)
    );

    lane_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo_1 (
        .clk   (clk_2f),
        .reset (reset),
        .push  (push_1),
        .pop   (pop && lane_sel),
        .flush (flush),
        .din   (data_stripe_1),
        .dout  (dout_1),
        .empty (empty_1),
        .full  (full_1),
        .level (level_1),
        .ovf   (ovf_1)
    );

    // Next-state, scheduling and flag logic.
    always_comb begin
        state_n    = state;
        lane_sel_n = lane_sel;
        skew_cnt_n = skew_cnt;
        data_n     = data_demux;
        valid_n    = 1'b0;
        skew_err_n = skew_err;
        ovf_err_n  = ovf_err;

        case (state)
            ST_IDLE: begin
                if (push_0 || push_1 || !empty_0 || !empty_1) begin
                    state_n    = ST_ALIGN;
                    skew_cnt_n = '0;
                end
            end
            ST_ALIGN: begin
                if (!empty_0 && !empty_1) begin
                    state_n    = ST_RUN;
                    lane_sel_n = 1'b0;
                end else if (skew_cnt == SW'(MAX_SKEW)) begin
                    state_n    = ST_ERR;
                    skew_err_n = 1'b1;
                end else if (empty_0 != empty_1) begin
                    skew_cnt_n = skew_cnt + SW'(1);
                end
            end
            ST_RUN: begin
                if (pop) begin
                    data_n     = lane_sel ? dout_1 : dout_0;
                    valid_n    = 1'b1;
                    lane_sel_n = !lane_sel;
                    skew_cnt_n = '0;
                end else if (lane_sel) begin
                    // Lane 1 owes its byte for this stripe pair; bound the wait.
                    if (skew_cnt == SW'(MAX_SKEW)) begin
                        state_n    = ST_ERR;
                        skew_err_n = 1'b1;
                    end else begin
                        skew_cnt_n = skew_cnt + SW'(1);
                    end
                end else if (empty_0 && empty_1) begin
                    state_n = ST_IDLE;
                end
            end
            ST_ERR: begin
                if (clear_err) begin
                    state_n    = ST_IDLE;
                    skew_err_n = 1'b0;
                    ovf_err_n  = 1'b0;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // Overflow overrides any other transition and may coincide with a skew error.
        if (ovf_0 || ovf_1) begin
            state_n   = ST_ERR;
            ovf_err_n = 1'b1;
        end
    end

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            state       <= ST_IDLE;
            lane_sel    <= 1'b0;
            skew_cnt    <= '0;
            data_demux  <= '0;
            valid_demux <= 1'b0;
            skew_err    <= 1'b0;
            ovf_err     <= 1'b0;
            aligned     <= 1'b0;
        end else begin
            state       <= state_n;
            lane_sel    <= lane_sel_n;
            skew_cnt    <= skew_cnt_n;
            data_demux  <= data_n;
            valid_demux <= valid_n;
            skew_err    <= skew_err_n;
            ovf_err     <= ovf_err_n;
            aligned     <= (state_n == ST_RUN);
        end
    end

endmodule

// File: tb/tb_unstripe_sched.sv
// Directed and random bench for unstripe_sched against a queue-based reference model.
module tb_unstripe_sched;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned MSKEW = 6;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    localparam int M_IDLE  = 0;
    localparam int M_ALIGN = 1;
    localparam int M_RUN   = 2;
    localparam int M_ERR   = 3;

    logic          clk_2f;
    logic          reset;
    logic [DW-1:0] data_stripe_0;
    logic          valid_stripe_0;
    logic [DW-1:0] data_stripe_1;
    logic          valid_stripe_1;
    logic          clear_err;
    logic [DW-1:0] data_demux;
    logic          valid_demux;
    logic          lane_sel;
    logic          aligned;
    logic          skew_err;
    logic          ovf_err;
    logic [LW-1:0] level_0;
    logic [LW-1:0] level_1;

    unstripe_sched #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .MAX_SKEW(MSKEW)) dut (
        .clk_2f         (clk_2f),
        .reset          (reset),
        .data_stripe_0  (data_stripe_0),
        .valid_stripe_0 (valid_stripe_0),
        .data_stripe_1  (data_stripe_1),
        .valid_stripe_1 (valid_stripe_1),
        .clear_err      (clear_err),
        .data_demux     (data_demux),
        .valid_demux    (valid_demux),
        .lane_sel       (lane_sel),
        .aligned        (aligned),
        .skew_err       (skew_err),
        .ovf_err        (ovf_err),
        .level_0        (level_0),
        .level_1        (level_1)
    );

    initial begin
        clk_2f = 1'b0;
        forever #5 clk_2f = ~clk_2f;
    end

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: two byte queues plus the scheduler's observable registers.
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    int            m_st;
    bit            m_sel;
    int            m_cnt;
    logic [DW-1:0] m_dout;
    bit            m_vout;
    bit            m_serr;
    bit            m_oerr;
    bit            m_al;
    logic [DW-1:0] got[$];

    task automatic model_reset();
        q0.delete();
        q1.delete();
        m_st = M_IDLE; m_sel = 1'b0; m_cnt = 0; m_dout = '0;
        m_vout = 1'b0; m_serr = 1'b0; m_oerr = 1'b0; m_al = 1'b0;
    endtask

    task automatic model_step(input bit v0, input logic [DW-1:0] d0,
                              input bit v1, input logic [DW-1:0] d1,
                              input bit clr, input bit rst);
        int            n0;
        int            n1;
        bit            in_err;
        bit            pop;
        bit            o0;
        bit            o1;
        bit            acc0;
        bit            acc1;
        logic [DW-1:0] head;
        if (rst) begin
            model_reset();
            return;
        end
        n0 = q0.size();
        n1 = q1.size();
        in_err = (m_st == M_ERR);
        pop = (m_st == M_RUN) && (m_sel ? (n1 > 0) : (n0 > 0));
        head = '0;
        if (pop) head = m_sel ? q1[0] : q0[0];
        acc0 = 0; acc1 = 0; o0 = 0; o1 = 0;
        if (!in_err && v0) begin
            if (n0 < int'(DEPTH) || (pop && !m_sel)) acc0 = 1; else o0 = 1;
        end
        if (!in_err && v1) begin
            if (n1 < int'(DEPTH) || (pop && m_sel)) acc1 = 1; else o1 = 1;
        end
        if (pop) begin
            if (m_sel) void'(q1.pop_front()); else void'(q0.pop_front());
        end
        if (acc0) q0.push_back(d0);
        if (acc1) q1.push_back(d1);
        m_vout = 1'b0;
        case (m_st)
            M_IDLE: begin
                if (acc0 || acc1 || n0 > 0 || n1 > 0) begin
                    m_st = M_ALIGN;
                    m_cnt = 0;
                end
            end
            M_ALIGN: begin
                if (n0 > 0 && n1 > 0) begin
                    m_st = M_RUN;
                    m_sel = 1'b0;
                end else if (m_cnt == int'(MSKEW)) begin
                    m_st = M_ERR;
                    m_serr = 1'b1;
                end else if ((n0 > 0) != (n1 > 0)) begin
                    m_cnt++;
                end
            end
            M_RUN: begin
                if (pop) begin
                    m_dout = head;
                    m_vout = 1'b1;
                    m_sel = !m_sel;
                    m_cnt = 0;
                end else if (m_sel) begin
                    if (m_cnt == int'(MSKEW)) begin
                        m_st = M_ERR;
                        m_serr = 1'b1;
                    end else begin
                        m_cnt++;
                    end
                end else if (n0 == 0 && n1 == 0) begin
                    m_st = M_IDLE;
                end
            end
            default: begin
                q0.delete();
                q1.delete();
                if (clr) begin
                    m_st = M_IDLE;
                    m_serr = 1'b0;
                    m_oerr = 1'b0;
                end
            end
        endcase
        if (o0 || o1) begin
            m_st = M_ERR;
            m_oerr = 1'b1;
        end
        m_al = (m_st == M_RUN);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("data_demux",  32'(data_demux),  32'(m_dout));
        chk("valid_demux", 32'(valid_demux), 32'(m_vout));
        chk("lane_sel",    32'(lane_sel),    32'(m_sel));
        chk("aligned",     32'(aligned),     32'(m_al));
        chk("skew_err",    32'(skew_err),    32'(m_serr));
        chk("ovf_err",     32'(ovf_err),     32'(m_oerr));
        chk("level_0",     32'(level_0),     32'(q0.size()));
        chk("level_1",     32'(level_1),     32'(q1.size()));
    endtask

    // One clock: drive inputs, advance the model, sample #1 after the edge.
    task automatic cyc(input bit v0, input logic [DW-1:0] d0,
                       input bit v1, input logic [DW-1:0] d1,
                       input bit clr, input bit rst);
        valid_stripe_0 = v0; data_stripe_0 = d0;
        valid_stripe_1 = v1; data_stripe_1 = d1;
        clear_err = clr; reset = rst;
        model_step(v0, d0, v1, d1, clr, rst);
        @(posedge clk_2f);
        #1;
        check_all();
        if (valid_demux) got.push_back(data_demux);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, '0, 0, '0, 0, 0);
    endtask

    task automatic chk_got(input string tag, input logic [DW-1:0] base, input int n);
        chk({tag, "_len"}, 32'(got.size()), 32'(n));
        for (int i = 0; i < n && i < got.size(); i++)
            chk({tag, "_byte"}, 32'(got[i]), 32'(base + DW'(i)));
    endtask

    initial begin
        logic [DW-1:0] rd0;
        logic [DW-1:0] rd1;
        int            p0;
        int            p1;
        int            nv;
        valid_stripe_0 = 0; valid_stripe_1 = 0; clear_err = 0;
        data_stripe_0 = '0; data_stripe_1 = '0; reset = 1;

        // Reset state
        cyc(0, '0, 0, '0, 0, 1);
        cyc(0, '0, 0, '0, 0, 1);
        chk("rst_valid", 32'(valid_demux), 32'd0);
        chk("rst_data",  32'(data_demux),  32'd0);
        idle(2);

        // Aligned burst: lane 0 on even cycles, lane 1 on odd cycles
        got.delete();
        for (int k = 0; k < 6; k++)
            cyc(k % 2 == 0, DW'(8'hA0 + k), k % 2 == 1, DW'(8'hA0 + k), 0, 0);
        idle(5);
        chk_got("burst", DW'(8'hA0), 6);
        chk("burst_idle_aligned", 32'(aligned), 32'd0);

        // Skew within limit: lane 1 starts four cycles after lane 0
        got.delete();
        cyc(1, 8'hB0, 0, '0, 0, 0);
        cyc(0, '0, 0, '0, 0, 0);
        cyc(1, 8'hB2, 0, '0, 0, 0);
        cyc(0, '0, 0, '0, 0, 0);
        cyc(0, '0, 1, 8'hB1, 0, 0);
        cyc(0, '0, 0, '0, 0, 0);
        cyc(0, '0, 1, 8'hB3, 0, 0);
        idle(6);
        chk_got("skew_ok", DW'(8'hB0), 4);
        chk("skew_ok_err", 32'(skew_err), 32'd0);

        // Skew error: lane 1 never shows up
        got.delete();
        cyc(1, 8'hC0, 0, '0, 0, 0);
        idle(10);
        chk("skew_err_set", 32'(skew_err), 32'd1);
        chk("skew_no_output", 32'(got.size()), 32'd0);
        cyc(0, '0, 0, '0, 1, 0);
        chk("skew_cleared", 32'(skew_err), 32'd0);
        idle(2);

        // Overflow: five back-to-back lane 0 pushes into a 4-deep FIFO
        for (int k = 0; k < 5; k++) cyc(1, DW'(8'hD0 + k), 0, '0, 0, 0);
        chk("ovf_set", 32'(ovf_err), 32'd1);
        idle(1);
        chk("ovf_flushed", 32'(level_0), 32'd0);
        cyc(0, '0, 0, '0, 1, 0);
        chk("ovf_cleared", 32'(ovf_err), 32'd0);
        idle(2);

        // Full lane 0 with simultaneous push and pop in RUN
        got.delete();
        cyc(1, 8'h10, 0, '0, 0, 0);
        cyc(1, 8'h12, 0, '0, 0, 0);
        cyc(1, 8'h14, 0, '0, 0, 0);
        cyc(1, 8'h16, 1, 8'h11, 0, 0);
        cyc(0, '0, 0, '0, 0, 0);
        cyc(1, 8'h18, 1, 8'h13, 0, 0);
        chk("full_pushpop_level", 32'(level_0), 32'(DEPTH));
        cyc(0, '0, 1, 8'h15, 0, 0);
        cyc(0, '0, 1, 8'h17, 0, 0);
        cyc(0, '0, 1, 8'h19, 0, 0);
        idle(10);
        chk("full_no_ovf", 32'(ovf_err), 32'd0);
        chk_got("full", DW'(8'h10), 10);

        // Reset mid-burst after three output bytes, then a fresh burst
        got.delete();
        for (int k = 0; k < 20 && got.size() < 3; k++)
            cyc(k % 2 == 0, DW'(8'h40 + k), k % 2 == 1, DW'(8'h40 + k), 0, 0);
        cyc(1, 8'h55, 1, 8'h56, 0, 1);
        chk("midrst_valid", 32'(valid_demux), 32'd0);
        chk("midrst_level0", 32'(level_0), 32'd0);
        chk("midrst_aligned", 32'(aligned), 32'd0);
        got.delete();
        for (int k = 0; k < 4; k++)
            cyc(k % 2 == 0, DW'(8'h60 + k), k % 2 == 1, DW'(8'h60 + k), 0, 0);
        idle(5);
        chk_got("fresh", DW'(8'h60), 4);

        // Random traffic in segments of varying lane activity
        for (int s = 0; s < 60; s++) begin
            p0 = $urandom_range(10, 90);
            p1 = $urandom_range(10, 90);
            nv = $urandom_range(20, 60);
            for (int k = 0; k < nv; k++) begin
                rd0 = DW'($urandom_range(255));
                rd1 = DW'($urandom_range(255));
                cyc($urandom_range(99) < p0, rd0, $urandom_range(99) < p1, rd1,
                    $urandom_range(7) == 0, $urandom_range(299) == 0);
            end
        end
        idle(4);
        cyc(0, '0, 0, '0, 1, 0);
        idle(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
